// File: rtl/bus_pkg.sv
// Shared constants, state encoding and helpers for the node-bus arbiter.
// Imported by bus_arbiter and rr_arbiter.
package bus_pkg;

    localparam int unsigned N          = 16;
    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned DATA_W     = 64;
    localparam int unsigned CRC_W      = 4;
    localparam int unsigned FRAME_BITS = 1 + 2 * ADDR_W + DATA_W + CRC_W;

    // One counter covers every field, so it is sized for the widest one.
    localparam int unsigned CNT_W  = $clog2(DATA_W);
    localparam int unsigned AIDX_W = $clog2(ADDR_W);
    localparam int unsigned CIDX_W = $clog2(CRC_W);

    localparam logic BUS_IDLE  = 1'b1;
    localparam logic START_BIT = 1'b0;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StSrc,
        StDst,
        StData,
        StCrc,
        StGap
    } state_e;

    function automatic logic [N-1:0] idx_to_onehot(input logic [ADDR_W-1:0] idx);
        return N'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above rr_last_i, wrapping modulo N.
// rr_last_i itself is examined last, so the most recently served node ranks lowest.
module rr_arbiter
    import bus_pkg::*;
(
    input  logic [N-1:0]      req_i,
    input  logic [ADDR_W-1:0] rr_last_i,
    output logic              valid_o,
    output logic [N-1:0]      grant_o,
    output logic [ADDR_W-1:0] idx_o
);

    logic              found;
    logic [ADDR_W-1:0] win;
    logic [ADDR_W-1:0] cand;

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        // N is a power of two, so the ADDR_W-bit add wraps modulo N for free.
        for (int unsigned i = 1; i <= N; i++) begin
            cand = rr_last_i + ADDR_W'(i);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    assign valid_o = found;
    assign idx_o   = win;
    assign grant_o = found ? idx_to_onehot(win) : '0;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and frame serialiser for the shared single-wire node bus.
// Frame: start bit, sender index, destination, payload, CRC -- all MSB first.
module bus_arbiter
    import bus_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [N-1:0]      req,
    input  logic [ADDR_W-1:0] frm_dst,
    input  logic [DATA_W-1:0] frm_data,
    input  logic [CRC_W-1:0]  frm_crc,
    output logic [N-1:0]      grant,
    output logic [ADDR_W-1:0] grant_idx,
    output logic [N-1:0]      ack,
    output logic              bus_tx,
    output logic              busy
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] rr_last_q, rr_last_d;
    logic [N-1:0]      grant_q, grant_d;
    logic [ADDR_W-1:0] grant_idx_q, grant_idx_d;
    logic [N-1:0]      ack_q, ack_d;
    logic              bus_tx_q, bus_tx_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CRC_W-1:0]  crc_q, crc_d;

    logic              win_valid;
    logic [N-1:0]      win_grant;
    logic [ADDR_W-1:0] win_idx;

    rr_arbiter u_rr_arbiter (
        .req_i     (req),
        .rr_last_i (rr_last_q),
        .valid_o   (win_valid),
        .grant_o   (win_grant),
        .idx_o     (win_idx)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_last_d   = rr_last_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ack_d       = '0;
        dst_d       = dst_q;
        data_d      = data_q;
        crc_d       = crc_q;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    state_d     = StLoad;
                    grant_d     = win_grant;
                    grant_idx_d = win_idx;
                    rr_last_d   = win_idx;
                end
            end
            StLoad: begin
                dst_d   = frm_dst;
                data_d  = frm_data;
                crc_d   = frm_crc;
                state_d = StStart;
            end
            StStart: begin
                state_d = StSrc;
                cnt_d   = CNT_W'(ADDR_W - 1);
            end
            StSrc: begin
                if (cnt_q == '0) begin
                    state_d = StDst;
                    cnt_d   = CNT_W'(ADDR_W - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDst: begin
                if (cnt_q == '0) begin
                    state_d = StData;
                    cnt_d   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StData: begin
                if (cnt_q == '0) begin
                    state_d = StCrc;
                    cnt_d   = CNT_W'(CRC_W - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StCrc: begin
                if (cnt_q == '0) begin
                    // Grant drops as ack rises so the two never overlap for a node.
                    state_d = StGap;
                    ack_d   = idx_to_onehot(grant_idx_q);
                    grant_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // bus_tx is registered: it is computed from the state being entered.
    always_comb begin
        bus_tx_d = BUS_IDLE;
        unique case (state_d)
            StStart: bus_tx_d = START_BIT;
            StSrc:   bus_tx_d = grant_idx_q[cnt_d[AIDX_W-1:0]];
            StDst:   bus_tx_d = dst_q[cnt_d[AIDX_W-1:0]];
            StData:  bus_tx_d = data_q[cnt_d];
            StCrc:   bus_tx_d = crc_q[cnt_d[CIDX_W-1:0]];
            default: bus_tx_d = BUS_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rr_last_q   <= ADDR_W'(N - 1);
            grant_q     <= '0;
            grant_idx_q <= '0;
            ack_q       <= '0;
            bus_tx_q    <= BUS_IDLE;
            dst_q       <= '0;
            data_q      <= '0;
            crc_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_last_q   <= rr_last_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ack_q       <= ack_d;
            bus_tx_q    <= bus_tx_d;
            dst_q       <= dst_d;
            data_q      <= data_d;
            crc_q       <= crc_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign ack       = ack_q;
    assign bus_tx    = bus_tx_q;
    assign busy      = (state_q != StIdle);

    a_grant_onehot0: assert property (@(posedge clock) disable iff (reset) $onehot0(grant_q));
    a_ack_onehot0:   assert property (@(posedge clock) disable iff (reset) $onehot0(ack_q));
    a_no_overlap:    assert property (@(posedge clock) disable iff (reset)
                                      (ack_q & grant_q) == '0);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: frame timing, serial content, round-robin order,
// mid-frame reset, input sampling and idle behaviour.
module tb_bus_arbiter;

    logic        clock;
    logic        reset;
    logic [15:0] req;
    logic [3:0]  frm_dst;
    logic [63:0] frm_data;
    logic [3:0]  frm_crc;
    logic [15:0] grant;
    logic [3:0]  grant_idx;
    logic [15:0] ack;
    logic        bus_tx;
    logic        busy;

    int checks = 0;
    int errors = 0;

    bus_arbiter u_dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .frm_dst   (frm_dst),
        .frm_data  (frm_data),
        .frm_crc   (frm_crc),
        .grant     (grant),
        .grant_idx (grant_idx),
        .ack       (ack),
        .bus_tx    (bus_tx),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [76:0] exp_frame(input logic [3:0] idx, input logic [3:0] dst,
                                              input logic [63:0] data, input logic [3:0] crc);
        return {1'b0, idx, dst, data, crc};
    endfunction

    function automatic logic [15:0] onehot(input logic [3:0] idx);
        logic [15:0] one;
        one = 16'h0001;
        return one << idx;
    endfunction

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Called at the negedge of cycle 0 with req already set; returns at the negedge of cycle 80.
    // drop_cyc / chg_cyc of 0 mean no mid-frame change.
    task automatic run_frame(input string tag, input logic [3:0] idx, input logic [3:0] dst,
                             input logic [63:0] data, input logic [3:0] crc,
                             input int drop_cyc, input logic [15:0] req_after,
                             input int chg_cyc, input logic [63:0] data_after);
        logic [76:0] stream;
        stream   = '0;
        frm_dst  = dst;
        frm_data = data;
        frm_crc  = crc;
        for (int c = 1; c <= 80; c++) begin
            @(negedge clock);
            if (c >= 2 && c <= 78) stream[78 - c] = bus_tx;
            if (c == 1) begin
                check_eq({tag, " grant c1"}, 128'(grant), 128'(onehot(idx)));
                check_eq({tag, " grant_idx c1"}, 128'(grant_idx), 128'(idx));
                check_eq({tag, " bus_tx c1"}, 128'(bus_tx), 128'(1'b1));
                check_eq({tag, " busy c1"}, 128'(busy), 128'(1'b1));
            end
            if (c == 40) check_eq({tag, " grant held c40"}, 128'(grant), 128'(onehot(idx)));
            if (c == 78) check_eq({tag, " ack c78"}, 128'(ack), 128'(0));
            if (c == 79) begin
                check_eq({tag, " ack c79"}, 128'(ack), 128'(onehot(idx)));
                check_eq({tag, " grant c79"}, 128'(grant), 128'(0));
                check_eq({tag, " bus_tx c79"}, 128'(bus_tx), 128'(1'b1));
            end
            if (c == 80) begin
                check_eq({tag, " busy c80"}, 128'(busy), 128'(1'b0));
                check_eq({tag, " ack c80"}, 128'(ack), 128'(0));
            end
            if (c == drop_cyc) req = req_after;
            if (c == chg_cyc) frm_data = data_after;
        end
        check_eq({tag, " stream"}, 128'(stream), 128'(exp_frame(idx, dst, data, crc)));
    endtask

    initial begin
        logic        tx_and;
        logic [15:0] grant_or;
        logic [15:0] ack_or;
        logic        busy_or;

        reset    = 1'b1;
        req      = '0;
        frm_dst  = '0;
        frm_data = '0;
        frm_crc  = '0;
        repeat (3) @(negedge clock);
        check_eq("rst grant", 128'(grant), 128'(0));
        check_eq("rst grant_idx", 128'(grant_idx), 128'(0));
        check_eq("rst ack", 128'(ack), 128'(0));
        check_eq("rst bus_tx", 128'(bus_tx), 128'(1'b1));
        check_eq("rst busy", 128'(busy), 128'(1'b0));
        reset = 1'b0;

        // 1: single node, minimal payload
        req = 16'h0001;
        run_frame("t1", 4'd0, 4'd1, 64'h1, 4'h1, 80, 16'h0000, 0, '0);

        // 2: four requesters held, back-to-back rotation
        do_reset();
        req = 16'h000F;
        run_frame("t2a", 4'd0, 4'h9, 64'hDEAD_BEEF_0123_4567, 4'hA, 0, '0, 0, '0);
        run_frame("t2b", 4'd1, 4'h6, 64'h8000_0000_0000_0001, 4'h5, 0, '0, 0, '0);
        run_frame("t2c", 4'd2, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 0, '0, 0, '0);
        run_frame("t2d", 4'd3, 4'h0, 64'h0000_0000_0000_0000, 4'h0, 0, '0, 0, '0);
        run_frame("t2e", 4'd0, 4'hC, 64'h5555_AAAA_3333_CCCC, 4'h3, 80, 16'h0000, 0, '0);

        // 3: wrap past empty nodes 3..15
        do_reset();
        req = 16'h0004;
        run_frame("t3a", 4'd2, 4'h1, 64'h0F0F_0F0F_0F0F_0F0F, 4'h2, 80, 16'h0005, 0, '0);
        run_frame("t3b", 4'd0, 4'h7, 64'h1234_5678_9ABC_DEF0, 4'h8, 0, '0, 0, '0);
        run_frame("t3c", 4'd2, 4'h3, 64'hCAFE_F00D_0000_FFFF, 4'h6, 80, 16'h0000, 0, '0);

        // 4: reset in the middle of the payload
        do_reset();
        req      = 16'h0001;
        frm_dst  = 4'h5;
        frm_data = 64'hFFFF_FFFF_FFFF_FFFF;
        frm_crc  = 4'h9;
        repeat (40) @(negedge clock);
        check_eq("t4 busy before reset", 128'(busy), 128'(1'b1));
        reset = 1'b1;
        @(negedge clock);
        check_eq("t4 bus_tx", 128'(bus_tx), 128'(1'b1));
        check_eq("t4 grant", 128'(grant), 128'(0));
        check_eq("t4 busy", 128'(busy), 128'(1'b0));
        check_eq("t4 ack", 128'(ack), 128'(0));
        reset = 1'b0;
        req   = 16'h8001;
        run_frame("t4b", 4'd0, 4'h2, 64'h0000_0001_0000_0001, 4'h4, 80, 16'h0000, 0, '0);

        // 5: req dropped and data changed mid-frame; dst equals sender
        req = 16'h0010;
        run_frame("t5", 4'd4, 4'h4, 64'hA5A5_5A5A_0000_FFFF, 4'hB, 10, 16'h0000,
                  20, 64'h0123_4567_89AB_CDEF);

        // 6: long idle
        tx_and   = 1'b1;
        grant_or = '0;
        ack_or   = '0;
        busy_or  = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            tx_and   = tx_and & bus_tx;
            grant_or = grant_or | grant;
            ack_or   = ack_or | ack;
            busy_or  = busy_or | busy;
        end
        check_eq("t6 bus_tx", 128'(tx_and), 128'(1'b1));
        check_eq("t6 grant", 128'(grant_or), 128'(0));
        check_eq("t6 ack", 128'(ack_or), 128'(0));
        check_eq("t6 busy", 128'(busy_or), 128'(1'b0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
